arm_mc_controller: RTL and testbench
====================================

# arm_mc_controller

Main controller for the multicycle variant of the ARM core, replacing the single-cycle decoder when instruction and data share one memory port. It decodes the latched instruction fields, runs the per-instruction state sequence, evaluates condition codes against an internal NZCV flag register, and drives every enable and mux select of the multicycle datapath.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- Cond  in  4  Instr[31:28], condition field
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1 (A), 1=PC
- ALUSrcB  out  2  00=RD2 (WriteData), 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR

## Operation
- States and unconditional outputs (anything unlisted is 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, NextPC=1 -> DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Op=00,Funct[5]=0 -> EXECR; Op=00,Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH (no-op).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 -> MEMREAD, else MEMWR.
  - MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - MEMWR: ResultSrc=00, AdrSrc=1, MemW=1 -> FETCH.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1 -> ALUWB.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegW=1 -> FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Branch=1 -> FETCH.
- ALU decode, ALUOp=0: ADD, FlagW=00. ALUOp=1, by cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; other cmd -> ADD with FlagW=00 and RegW suppressed. FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ADD or SUB).
- Condition: CondEx from stored flags: 0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V, 1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110 1, 1111 0.
- CondExR: 1-bit register loaded with CondEx at the end of DECODE only; gates all conditional effects of the instruction, so an instruction never sees flags it sets itself.
- PCS = Branch | (RegW & Rd==1111).
- Outputs: PCWrite = NextPC | (PCS & CondExR); RegWrite = RegW & CondExR; MemWrite = MemW & CondExR.
- Flags: NZ <= ALUFlags[3:2] when FlagW[1] & CondExR; CV <= ALUFlags[1:0] when FlagW[0] & CondExR; updated only at the end of EXECR/EXECI.

## Timing
- Reset: state=FETCH, flags=0000, CondExR=0, asynchronously. While reset is high: PCWrite, IRWrite, RegWrite and MemWrite are forced 0, and selects hold their FETCH values. First fetch is the first rising edge after reset deasserts.
- Cycles per instruction: B=3, data-processing=4, STR=4, LDR=5, Op=11=2.
- Outputs are Moore (state) plus CondExR and the latched fields. No output depends combinationally on ALUFlags.
- Failed condition: the state sequence is unchanged. All writes are suppressed, and the PC advances only via FETCH.
- Reset asserted mid-instruction: abort immediately. No partial write occurs after reset rises.

## Test plan
- Reset then release, Instr=E2800005 (ADD R0,R0,#5): states FETCH,DECODE,EXECI,ALUWB. RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH; IRWrite=1 only in FETCH.
- E2500000 (SUBS R0,R0,#0) with ALUFlags=0100 in EXECI, then 0A000002 (BEQ): flags=0100. BEQ takes 3 cycles with PCWrite=1 in BRANCH.
- Flags=0000, 0A000002 (BEQ): PCWrite=0 in BRANCH; next FETCH follows.
- E5901000 (LDR): FETCH,DECODE,MEMADR,MEMREAD,MEMWB. AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. E5801000 (STR): MemWrite=1 only in MEMWR.
- E080F001 (ADD PC,R0,R1): PCWrite=1 and RegWrite=1 in ALUWB. Op=11 word: back to FETCH after DECODE with no writes.
- Assert reset during MEMWR: MemWrite drops to 0 immediately. After release: state=FETCH, flags=0000.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Multicycle ARM main controller: instruction FSM, ALU decode,
// condition evaluation against internal NZCV, datapath control.
module arm_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op;
    logic       cmd_ok, cond_ex, pcs;
    logic [1:0] alu_ctl, flag_w;
    logic       fn, fz, fc, fv;

    assign {fn, fz, fc, fv} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = fz;
            4'b0001: cond_ex = ~fz;
            4'b0010: cond_ex = fc;
            4'b0011: cond_ex = ~fc;
            4'b0100: cond_ex = fn;
            4'b0101: cond_ex = ~fn;
            4'b0110: cond_ex = fv;
            4'b0111: cond_ex = ~fv;
            4'b1000: cond_ex = fc & ~fz;
            4'b1001: cond_ex = ~fc | fz;
            4'b1010: cond_ex = (fn == fv);
            4'b1011: cond_ex = (fn != fv);
            4'b1100: cond_ex = ~fz & (fn == fv);
            4'b1101: cond_ex = fz | (fn != fv);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Unsupported commands execute as ADD but never write back or set flags.
    always_comb begin
        cmd_ok  = 1'b1;
        alu_ctl = 2'b00;
        case (Funct[4:1])
            4'b0100: alu_ctl = 2'b00;
            4'b0010: alu_ctl = 2'b01;
            4'b0000: alu_ctl = 2'b10;
            4'b1100: alu_ctl = 2'b11;
            default: cmd_ok  = 1'b0;
        endcase
    end

    assign flag_w = (alu_op & cmd_ok)
                  ? {Funct[0], Funct[0] & ~alu_ctl[1]} : 2'b00;

    always_comb begin
        state_d   = state_q;
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        ir_w      = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? S_MEMREAD : S_MEMWR;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alu_op  = 1'b1;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = cmd_ok;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign pcs        = branch | (reg_w & (Rd == 4'hF));
    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};

    // Write strobes are masked by reset so an abort never leaks a write.
    assign PCWrite  = ~reset & (next_pc | (pcs & condex_q));
    assign IRWrite  = ~reset & ir_w;
    assign RegWrite = ~reset & reg_w & condex_q;
    assign MemWrite = ~reset & mem_w & condex_q;

    always_comb begin
        condex_d = (state_q == S_DECODE) ? cond_ex : condex_q;
        flags_d  = flags_q;
        if (alu_op & condex_q) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: per-instruction phase model with
// randomized instruction words and ALU flags.
module tb_arm_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    arm_mc_controller dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_flags;
    logic       m_cex;
    logic       force_en;
    logic [3:0] force_val;
    logic [15:0] obs;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c,
                                        input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic known_cmd(input logic [3:0] cmd);
        return cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        if (cmd == 4'd2)  return 2'b01;
        if (cmd == 4'd0)  return 2'b10;
        if (cmd == 4'd12) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [15:0] expect_vec(input string ph,
                                               input logic [31:0] w,
                                               input logic cex);
        logic [1:0] op;
        logic [3:0] cmd, rd;
        logic       pcw, adr, memw, irw, regw, a;
        logic [1:0] rs, b, alu;
        op  = w[27:26];
        cmd = w[24:21];
        rd  = w[15:12];
        {pcw, adr, memw, irw, regw, a} = 6'b0;
        rs = 2'b00; b = 2'b00; alu = 2'b00;
        if (ph == "F") begin
            pcw = 1; irw = 1; rs = 2'b10; a = 1; b = 2'b10;
        end else if (ph == "D") begin
            rs = 2'b10; a = 1; b = 2'b10;
        end else if (ph == "MA") begin
            b = 2'b01;
        end else if (ph == "MR") begin
            adr = 1;
        end else if (ph == "MWB") begin
            rs = 2'b01; regw = cex; pcw = cex && rd == 4'hF;
        end else if (ph == "ST") begin
            adr = 1; memw = cex;
        end else if (ph == "XR") begin
            alu = alu_of(cmd);
        end else if (ph == "XI") begin
            b = 2'b01; alu = alu_of(cmd);
        end else if (ph == "AW") begin
            regw = cex && known_cmd(cmd); pcw = regw && rd == 4'hF;
        end else if (ph == "BR") begin
            b = 2'b01; rs = 2'b10; pcw = cex;
        end
        return {pcw, adr, memw, irw, regw, rs, a, b, op,
                op == 2'b01, op == 2'b10, alu};
    endfunction

    task automatic run_instr(input logic [31:0] w, input int abort_ph,
                             output int ncyc, output logic [15:0] last);
        string      ph[$];
        logic [3:0] cmd;
        cmd = w[24:21];
        ph = {"F", "D"};
        case (w[27:26])
            2'b00: begin
                ph.push_back(w[25] ? "XI" : "XR");
                ph.push_back("AW");
            end
            2'b01: begin
                ph.push_back("MA");
                if (w[20]) begin
                    ph.push_back("MR");
                    ph.push_back("MWB");
                end else begin
                    ph.push_back("ST");
                end
            end
            2'b10: ph.push_back("BR");
            default: ;
        endcase
        Cond  = w[31:28];
        Op    = w[27:26];
        Funct = w[25:20];
        Rd    = w[15:12];
        ncyc  = 0;
        last  = 16'h0;
        foreach (ph[i]) begin
            ALUFlags = force_en ? force_val : 4'($urandom_range(0, 15));
            #1;
            chk({"out_", ph[i]}, obs, expect_vec(ph[i], w, m_cex));
            ncyc++;
            last = obs;
            if (i == abort_ph) begin
                reset = 1'b1;
                #1;
                chk("reset_abort", obs,
                    expect_vec("F", w, 1'b0) & ~16'h9000);
                m_flags = 4'b0000;
                m_cex   = 1'b0;
                @(negedge clk);
                #1 reset = 1'b0;
                return;
            end
            if (ph[i] == "D")
                m_cex = cond_holds(w[31:28], m_flags);
            if ((ph[i] == "XR" || ph[i] == "XI") && m_cex && w[20] &&
                known_cmd(cmd)) begin
                m_flags[3:2] = ALUFlags[3:2];
                if (cmd == 4'd4 || cmd == 4'd2)
                    m_flags[1:0] = ALUFlags[1:0];
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          n;
        logic [15:0] last;
        logic [31:0] w;
        reset     = 1'b1;
        force_en  = 1'b0;
        force_val = 4'b0000;
        m_flags   = 4'b0000;
        m_cex     = 1'b0;
        Cond = 4'hE; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;
        @(negedge clk);
        #1;
        chk("reset_outputs", obs, 16'h0580);
        @(negedge clk);
        reset = 1'b0;

        run_instr(32'hE2800005, -1, n, last);
        chk("add_cycles", 16'(n), 16'd4);
        chk("add_aluwb", last, 16'h0800);

        force_en = 1'b1; force_val = 4'b0100;
        run_instr(32'hE2500000, -1, n, last);
        force_en = 1'b0;
        chk("subs_model_flags", 16'(m_flags), 16'h0004);
        run_instr(32'h0A000002, -1, n, last);
        chk("beq_cycles", 16'(n), 16'd3);
        chk("beq_taken_pcw", 16'(last[15]), 16'd1);

        run_instr(32'hE5901000, -1, n, last);
        chk("ldr_cycles", 16'(n), 16'd5);
        chk("ldr_memwb", last, 16'h0A18);
        run_instr(32'hE5801000, -1, n, last);
        chk("str_cycles", 16'(n), 16'd4);
        chk("str_memwr", last, 16'h6018);

        run_instr(32'hE080F001, -1, n, last);
        chk("add_pc_aluwb", last, 16'h8800);
        run_instr(32'hEC000000, -1, n, last);
        chk("op11_cycles", 16'(n), 16'd2);

        force_en = 1'b1; force_val = 4'b0100;
        run_instr(32'hE2500000, -1, n, last);
        force_en = 1'b0;
        run_instr(32'hE5801000, 3, n, last);
        chk("str_memw_before_abort", 16'(last[13]), 16'd1);
        run_instr(32'h0A000002, -1, n, last);
        chk("beq_after_reset_pcw", 16'(last[15]), 16'd0);

        for (int k = 0; k < 400; k++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
            run_instr(w, -1, n, last);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
